// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared combinational ALU.
// Round-robin grant, one op in flight, registered response.
module alu_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int CONTROLL_WIDTH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [1:0]                req_valid_i,
  output logic [1:0]                req_ready_o,
  input  logic [DATA_WIDTH-1:0]     req0_op1_i,
  input  logic [DATA_WIDTH-1:0]     req0_op2_i,
  input  logic [CONTROLL_WIDTH-1:0] req0_ctrl_i,
  input  logic [DATA_WIDTH-1:0]     req1_op1_i,
  input  logic [DATA_WIDTH-1:0]     req1_op2_i,
  input  logic [CONTROLL_WIDTH-1:0] req1_ctrl_i,
  output logic [DATA_WIDTH-1:0]     alu_op1_o,
  output logic [DATA_WIDTH-1:0]     alu_op2_o,
  output logic [CONTROLL_WIDTH-1:0] alu_ctrl_o,
  input  logic [DATA_WIDTH-1:0]     alu_result_i,
  input  logic                      alu_zero_i,
  output logic                      resp_valid_o,
  input  logic                      resp_ready_i,
  output logic                      resp_id_o,
  output logic [DATA_WIDTH-1:0]     resp_result_o,
  output logic                      resp_zero_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic                      r_ptr;
  logic                      r_req_id;
  logic [DATA_WIDTH-1:0]     r_op1;
  logic [DATA_WIDTH-1:0]     r_op2;
  logic [CONTROLL_WIDTH-1:0] r_ctrl;
  logic                      r_resp_id;
  logic [DATA_WIDTH-1:0]     r_resp_result;
  logic                      r_resp_zero;
  logic [1:0]                w_grant;
  logic [1:0]                w_ready;
  logic                      w_hs;
  logic                      w_hs_id;

  // Grant the sole requester, or the pointed-to one on contention
  always_comb begin
    w_grant = 2'b00;
    case (req_valid_i)
      2'b01:   w_grant = 2'b01;
      2'b10:   w_grant = 2'b10;
      2'b11:   w_grant = r_ptr ? 2'b10 : 2'b01;
      default: w_grant = 2'b00;
    endcase
  end

  // Ready only in IDLE and never while reset is held
  always_comb begin
    w_ready = 2'b00;
    if (rst_ni && (r_state == IDLE)) begin
      w_ready = w_grant;
    end
  end

  assign w_hs    = |(req_valid_i & w_ready);
  assign w_hs_id = w_ready[1];

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: IDLE -> EXEC -> RESP -> IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_hs) w_state_nxt = EXEC;
      EXEC:    w_state_nxt = RESP;
      RESP:    if (resp_ready_i) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Capture granted operands and rotate the priority pointer
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_ptr    <= 1'b0;
      r_req_id <= 1'b0;
      r_op1    <= '0;
      r_op2    <= '0;
      r_ctrl   <= '0;
    end else if (w_hs) begin
      r_ptr    <= ~w_hs_id;
      r_req_id <= w_hs_id;
      r_op1    <= w_hs_id ? req1_op1_i : req0_op1_i;
      r_op2    <= w_hs_id ? req1_op2_i : req0_op2_i;
      r_ctrl   <= w_hs_id ? req1_ctrl_i : req0_ctrl_i;
    end
  end

  // Latch the ALU result at the end of the single EXEC cycle
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_resp_id     <= 1'b0;
      r_resp_result <= '0;
      r_resp_zero   <= 1'b0;
    end else if (r_state == EXEC) begin
      r_resp_id     <= r_req_id;
      r_resp_result <= alu_result_i;
      r_resp_zero   <= alu_zero_i;
    end
  end

  assign req_ready_o   = w_ready;
  assign alu_op1_o     = r_op1;
  assign alu_op2_o     = r_op2;
  assign alu_ctrl_o    = r_ctrl;
  assign resp_valid_o  = (r_state == RESP);
  assign resp_id_o     = r_resp_id;
  assign resp_result_o = r_resp_result;
  assign resp_zero_o   = r_resp_zero;

endmodule
